// File: rtl/control_multi_if.sv
// Control bundle between the multi-cycle MIPS control FSM (master) and its datapath (slave).
interface control_multi_if;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  opcode, zero,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal_op
  );

  modport slave (
    output opcode, zero,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal_op
  );
endinterface

// File: rtl/control_multi.sv
// Multi-cycle MIPS control FSM with Moore outputs registered from the next state.
// Optional macro CONTROL_MULTI_TRAP_EN: unimplemented opcodes trap (state 10, illegal_op=1) until reset.
module control_multi #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  control_multi_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [3:0] LAST   = 4'(MEM_LAT - 1);

  state_t     r_state, w_next_state;
  logic [3:0] r_wcnt, w_next_wcnt;
  logic       r_pc_write, r_pc_write_cond, r_iord, r_mem_read, r_mem_write, r_ir_write;
  logic       r_memto_reg, r_reg_dst, r_reg_write, r_alu_src_a;
  logic [1:0] r_alu_src_b, r_alu_op, r_pc_source;

  // wcnt only advances inside a memory state; every other transition clears it.
  always_comb begin
    w_next_state = r_state;
    w_next_wcnt  = 4'd0;
    case (r_state)
      S_FETCH:  if (r_wcnt == LAST) w_next_state = S_DECODE;
                else w_next_wcnt = r_wcnt + 4'd1;
      S_DECODE: case (bus.opcode)
                  OP_LW, OP_SW: w_next_state = S_MEMADR;
                  OP_R:         w_next_state = S_EXEC;
                  OP_BEQ:       w_next_state = S_BRANCH;
                  OP_J:         w_next_state = S_JUMP;
`ifdef CONTROL_MULTI_TRAP_EN
                  default:      w_next_state = S_TRAP;
`else
                  default:      w_next_state = S_FETCH;
`endif
                endcase
      S_MEMADR: w_next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (r_wcnt == LAST) w_next_state = S_MEMWB;
                else w_next_wcnt = r_wcnt + 4'd1;
      S_MEMWR:  if (r_wcnt == LAST) w_next_state = S_FETCH;
                else w_next_wcnt = r_wcnt + 4'd1;
      S_EXEC:   w_next_state = S_RWB;
      S_TRAP:   w_next_state = S_TRAP;
      default:  w_next_state = S_FETCH;
    endcase
    if (rst) begin
      w_next_state = S_FETCH;
      w_next_wcnt  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_wcnt  <= w_next_wcnt;
    end
    r_pc_write      <= 1'b0;
    r_pc_write_cond <= 1'b0;
    r_iord          <= 1'b0;
    r_mem_read      <= 1'b0;
    r_mem_write     <= 1'b0;
    r_ir_write      <= 1'b0;
    r_memto_reg     <= 1'b0;
    r_reg_dst       <= 1'b0;
    r_reg_write     <= 1'b0;
    r_alu_src_a     <= 1'b0;
    r_alu_src_b     <= 2'b00;
    r_alu_op        <= 2'b00;
    r_pc_source     <= 2'b00;
    case (w_next_state)
      S_FETCH: begin
        r_mem_read  <= 1'b1;
        r_alu_src_b <= 2'b01;
        r_ir_write  <= (w_next_wcnt == LAST);
        r_pc_write  <= (w_next_wcnt == LAST);
      end
      S_DECODE: r_alu_src_b <= 2'b11;
      S_MEMADR: begin
        r_alu_src_a <= 1'b1;
        r_alu_src_b <= 2'b10;
      end
      S_MEMRD: begin
        r_mem_read <= 1'b1;
        r_iord     <= 1'b1;
      end
      S_MEMWB: begin
        r_reg_write <= 1'b1;
        r_memto_reg <= 1'b1;
      end
      S_MEMWR: begin
        r_mem_write <= 1'b1;
        r_iord      <= 1'b1;
      end
      S_EXEC: begin
        r_alu_src_a <= 1'b1;
        r_alu_op    <= 2'b10;
      end
      S_RWB: begin
        r_reg_write <= 1'b1;
        r_reg_dst   <= 1'b1;
      end
      S_BRANCH: begin
        r_alu_src_a     <= 1'b1;
        r_alu_op        <= 2'b01;
        r_pc_write_cond <= 1'b1;
        r_pc_source     <= 2'b01;
      end
      S_JUMP: begin
        r_pc_write  <= 1'b1;
        r_pc_source <= 2'b10;
      end
      default: ;
    endcase
  end

`ifdef CONTROL_MULTI_TRAP_EN
  logic r_illegal_op;
  always_ff @(posedge clk) begin
    r_illegal_op <= (w_next_state == S_TRAP);
  end
  assign bus.illegal_op = r_illegal_op;
`else
  assign bus.illegal_op = 1'b0;
`endif

  // Strobes that change architectural state are killed while reset is held.
  assign bus.PCWrite     = r_pc_write & ~rst;
  assign bus.PCWriteCond = r_pc_write_cond & ~rst;
  assign bus.MemRead     = r_mem_read & ~rst;
  assign bus.MemWrite    = r_mem_write & ~rst;
  assign bus.IRWrite     = r_ir_write & ~rst;
  assign bus.RegWrite    = r_reg_write & ~rst;
  assign bus.IorD        = r_iord;
  assign bus.MemtoReg    = r_memto_reg;
  assign bus.RegDst      = r_reg_dst;
  assign bus.ALUSrcA     = r_alu_src_a;
  assign bus.ALUSrcB     = r_alu_src_b;
  assign bus.ALUOp       = r_alu_op;
  assign bus.PCSource    = r_pc_source;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_control_multi.sv
// Scoreboard bench: three FSM instances (MEM_LAT 1,2,3) run random instruction streams against a cycle-sequence model.
module tb_control_multi;
  logic clk;
  int   checks;
  int   failures;
  int   n_done;

`ifdef CONTROL_MULTI_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op}
  function automatic logic [20:0] exp_out(int st, bit last);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, op, ps;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'd0; op = 2'd0; ps = 2'd0;
    case (st)
      0:  begin mr = 1; sb = 2'd1; irw = last; pw = last; end
      1:  sb = 2'd3;
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; op = 2'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 2'd1; pwc = 1; ps = 2'd1; end
      9:  begin pw = 1; ps = 2'd2; end
      10: ill = 1;
      default: ;
    endcase
    return {4'(st), pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ill};
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    n_done = 0;
    for (int c = 0; c < 20000 && n_done < 3; c++) @(posedge clk);
    checks++;
    if (n_done < 3) begin
      failures++;
      $display("FAIL timeout_all: done=%0d want 3", n_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = g + 1;
    logic        rst_l;
    logic [5:0]  op_r;
    logic [20:0] act;
    logic [20:0] q[$];
    int          mode;
    int          n_insn;
    int          rst_cyc;

    control_multi_if bus ();
    control_multi #(.MEM_LAT(L)) dut (.clk(clk), .rst(rst_l), .bus(bus));

    assign bus.opcode = op_r;
    assign bus.zero   = 1'b0;
    assign act = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};

    task automatic push_fetch();
      for (int i = 0; i < L; i++) q.push_back(exp_out(0, i == L - 1));
    endtask

    // Called when the model's fetch completes: choose the next instruction and predict its cycles.
    task automatic issue();
      logic [5:0] op;
      bit trapped;
      trapped = 1'b0;
      if (mode == 2) op = 6'd8;
      else if (mode == 1) op = 6'd43;
      else begin
        case ($urandom_range(0, 4))
          0: op = 6'd0;
          1: op = 6'd35;
          2: op = 6'd43;
          3: op = 6'd4;
          default: op = 6'd2;
        endcase
      end
      op_r = op;
      q.push_back(exp_out(1, 1'b0));
      case (op)
        6'd0:  begin q.push_back(exp_out(6, 1'b0)); q.push_back(exp_out(7, 1'b0)); end
        6'd35: begin
          q.push_back(exp_out(2, 1'b0));
          for (int i = 0; i < L; i++) q.push_back(exp_out(3, 1'b0));
          q.push_back(exp_out(4, 1'b0));
        end
        6'd43: begin
          q.push_back(exp_out(2, 1'b0));
          for (int i = 0; i < L; i++) q.push_back(exp_out(5, 1'b0));
        end
        6'd4:  q.push_back(exp_out(8, 1'b0));
        6'd2:  q.push_back(exp_out(9, 1'b0));
        default: if (TRAP_EN) begin
          trapped = 1'b1;
          for (int i = 0; i < 6; i++) q.push_back(exp_out(10, 1'b0));
        end
      endcase
      if (!trapped) push_fetch();
      n_insn++;
    endtask

    // Monitor: compares every cycle away from the clock edge.
    initial begin
      logic [20:0] e;
      rst_cyc = 0;
      forever begin
        @(negedge clk);
        if (rst_l) begin
          checks++;
          if ({act[16], act[15], act[13], act[12], act[11], act[8]} !== 6'b0) begin
            failures++;
            $display("FAIL L=%0d rst_gate: enables=%b want 000000", L,
                     {act[16], act[15], act[13], act[12], act[11], act[8]});
          end
          if (rst_cyc >= 1) begin
            checks++;
            if (act[20:17] !== 4'd0 || act[0] !== 1'b0) begin
              failures++;
              $display("FAIL L=%0d rst_state: state=%0d illegal=%b want 0/0", L, act[20:17], act[0]);
            end
          end
          rst_cyc++;
        end else begin
          rst_cyc = 0;
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL L=%0d underflow: got %h with no expectation", L, act);
          end else begin
            e = q.pop_front();
            if (act !== e) begin
              failures++;
              $display("FAIL L=%0d seq: got %h want %h (state %0d want %0d)", L, act, e,
                       act[20:17], e[20:17]);
            end
            if (e[11]) issue();
          end
        end
      end
    end

    task automatic wait_insn(int target);
      for (int c = 0; c < 3000 && n_insn < target; c++) @(posedge clk);
      checks++;
      if (n_insn < target) begin
        failures++;
        $display("FAIL L=%0d timeout_insn: got %0d want %0d", L, n_insn, target);
      end
    endtask

    task automatic do_reset(int cycles);
      rst_l = 1'b1;
      q.delete();
      repeat (cycles) @(posedge clk);
      #1;
      mode = 0;
      rst_l = 1'b0;
      push_fetch();
    endtask

    initial begin
      bit hit;
      rst_l = 1'b1;
      op_r = 6'd0;
      mode = 0;
      n_insn = 0;
      do_reset(2);
      wait_insn(40);

      // Abort a store during its first write cycle.
      mode = 1;
      hit = 1'b0;
      for (int c = 0; c < 500 && !hit; c++) begin
        @(posedge clk);
        #1;
        hit = (bus.state == 4'd5);
      end
      checks++;
      if (!hit) begin
        failures++;
        $display("FAIL L=%0d timeout_memwr: state=%0d want 5", L, bus.state);
      end
      do_reset(2);
      wait_insn(n_insn + 5);

      // Unimplemented opcode.
      mode = 2;
      hit = 1'b0;
      for (int c = 0; c < 500 && !hit; c++) begin
        @(posedge clk);
        #1;
        hit = (bus.state == 4'd1 && op_r == 6'd8);
      end
      checks++;
      if (!hit) begin
        failures++;
        $display("FAIL L=%0d timeout_illegal: state=%0d op=%0d", L, bus.state, op_r);
      end
      repeat (4) @(posedge clk);
      #1;
      do_reset(2);
      wait_insn(n_insn + 15);
      n_done++;
    end
  end
endmodule
